// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver with 2-flop input synchronizer and mid-bit
//            sampling; emits each good byte with a one-cycle valid strobe.
// Revision : 1.0
// ============================================================================
module uart_rx #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       axiid,
    output logic       axiov,
    output logic [7:0] axiod
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW           = $clog2(CLKS_PER_BIT) + 1;

    localparam logic [CW-1:0] c_full_last = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] c_half_last = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_start = 2'd1;
    localparam logic [1:0] c_data  = 2'd2;
    localparam logic [1:0] c_stop  = 2'd3;

    logic          r_sync1;
    logic          r_sync2;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_axiov;
    logic [7:0]    r_axiod;

    logic          w_rx;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    w_bit_idx_nxt;
    logic [7:0]    w_shift_nxt;
    logic          w_axiov_nxt;
    logic [7:0]    w_axiod_nxt;

    assign w_rx  = r_sync2;
    assign axiov = r_axiov;
    assign axiod = r_axiod;

    // Synchronizer presets to 1 so reset looks like an idle line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_state   <= c_idle;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_axiov   <= 1'b0;
            r_axiod   <= '0;
        end else begin
            r_sync1   <= axiid;
            r_sync2   <= r_sync1;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_axiov   <= w_axiov_nxt;
            r_axiod   <= w_axiod_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + 1'b1;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_axiov_nxt   = 1'b0;
        w_axiod_nxt   = r_axiod;
        case (r_state)
            c_idle: begin
                w_cnt_nxt = '0;
                if (!w_rx) begin
                    w_state_nxt = c_start;
                end
            end
            c_start: begin
                if (r_cnt == c_half_last) begin
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = w_rx ? c_idle : c_data;
                end
            end
            c_data: begin
                if (r_cnt == c_full_last) begin
                    w_cnt_nxt              = '0;
                    w_shift_nxt[r_bit_idx] = w_rx;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = c_stop;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
            default: begin
                // Leave mid stop bit so a back-to-back start edge is not missed.
                if (r_cnt == c_full_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_idle;
                    if (w_rx) begin
                        w_axiov_nxt = 1'b1;
                        w_axiod_nxt = r_shift;
                    end
                end
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Directed frames against a frame-level expectation queue.
// Revision : 1.0
// ============================================================================
module tb_uart_rx;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 100_000;
    localparam int N      = CLK_HZ / BAUD;
    localparam int LAT    = (19 * N) / 2;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       axiid = 1'b1;
    logic       axiov;
    logic [7:0] axiod;

    uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .axiid (axiid),
        .axiov (axiov),
        .axiod (axiod)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        int         lo;
        int         hi;
    } exp_t;

    exp_t       q[$];
    int         checks   = 0;
    int         errors   = 0;
    int         cyc      = 0;
    logic [7:0] hold_val = 8'h00;
    logic       prev_v   = 1'b0;
    logic       rst_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // A good frame must pulse 9.5 bit times after its start edge, plus a few clocks.
    task automatic compare_cycle();
        cyc++;
        if (rst_seen) begin
            q.delete();
            hold_val = 8'h00;
            check("reset_axiov", 32'(axiov), 32'd0);
            check("reset_axiod", 32'(axiod), 32'd0);
        end else if (axiov) begin
            if (q.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                check("pulse_window", 32'(cyc >= q[0].lo && cyc <= q[0].hi), 32'd1);
                check("pulse_data", 32'(axiod), 32'(q[0].b));
                hold_val = q[0].b;
                void'(q.pop_front());
            end
        end else begin
            check("hold_data", 32'(axiod), 32'(hold_val));
            if (q.size() > 0 && cyc > q[0].hi) begin
                check("missed_pulse", 32'd0, 32'd1);
                void'(q.pop_front());
            end
        end
        check("double_pulse", 32'(axiov && prev_v), 32'd0);
        prev_v   = axiov;
        rst_seen = rst;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // abort_bit >= 0 pulses rst in the middle of that data bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int abort_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        if (stop_bit && abort_bit < 0) begin
            q.push_back('{b: b, lo: cyc + LAT, hi: cyc + LAT + 6});
        end
        for (int i = 0; i < 10; i++) begin
            axiid = bits[i];
            if (abort_bit >= 0 && i == abort_bit + 1) begin
                tick(N / 2);
                rst = 1'b1;
                tick(2);
                rst   = 1'b0;
                axiid = 1'b1;
                return;
            end
            tick(N);
        end
        axiid = 1'b1;
    endtask

    initial begin
        tick(3);
        fork
            forever begin
                @(negedge clk);
                compare_cycle();
            end
        join_none
        tick(2);
        rst = 1'b0;

        tick(40);
        check("idle_axiov", 32'(axiov), 32'd0);
        check("idle_axiod", 32'(axiod), 32'h00);

        send_frame(8'hAA, 1'b1, -1);
        check("frame_aa", 32'(axiod), 32'hAA);
        send_frame(8'hCC, 1'b1, -1);
        check("frame_cc", 32'(axiod), 32'hCC);

        axiid = 1'b0;
        tick(N / 4);
        axiid = 1'b1;
        tick(3 * N);
        check("false_start_hold", 32'(axiod), 32'hCC);
        send_frame(8'h55, 1'b1, -1);
        check("frame_55", 32'(axiod), 32'h55);
        tick(N);

        send_frame(8'h3C, 1'b0, -1);
        tick(2 * N);
        check("framing_error_hold", 32'(axiod), 32'h55);
        send_frame(8'h81, 1'b1, -1);
        check("frame_81", 32'(axiod), 32'h81);
        tick(N);

        send_frame(8'hA5, 1'b1, 4);
        check("abort_axiod", 32'(axiod), 32'h00);
        check("abort_axiov", 32'(axiov), 32'd0);
        tick(2 * N);
        send_frame(8'hF0, 1'b1, -1);
        check("frame_f0", 32'(axiod), 32'hF0);
        tick(3 * N);

        check("all_pulses_seen", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
